// File: rtl/ps2_mouse_packet_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_mouse_packet_rx
// Purpose  : Receives the PS/2 mouse serial stream, assembles 3-byte movement
//            packets and presents status/deltaX/deltaY with a one-cycle tx
//            strobe. Framing, sync and inactivity errors raise frame_err.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_mouse_packet_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] status,
  output logic [7:0] deltaX,
  output logic [7:0] deltaY,
  output logic       tx,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic          clk_meta, clk_sync, data_meta, data_sync;
  logic          clk_filt, clk_filt_q;
  logic [FW-1:0] filt_cnt;
  logic          sample_evt;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [1:0]    byte_idx;
  logic [7:0]    stage_status, stage_x;
  logic [TW-1:0] tout_cnt;

  // Two-flop synchronisers; idle-high so reset does not look like an edge.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Deglitch: filtered clock follows only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_q <= clk_filt;
      if (clk_sync == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        clk_filt <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // One sample event per filtered falling edge.
  assign sample_evt = clk_filt_q & ~clk_filt;

  // Bit FSM, packet assembly and inactivity timeout; outputs are registered.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      parity_bit   <= 1'b0;
      byte_idx     <= '0;
      stage_status <= '0;
      stage_x      <= '0;
      tout_cnt     <= '0;
      status       <= '0;
      deltaX       <= '0;
      deltaY       <= '0;
      tx           <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      tx        <= 1'b0;
      frame_err <= 1'b0;

      if (sample_evt) begin
        tout_cnt <= '0;
      end else if (tout_cnt != TOUT_MAX) begin
        tout_cnt <= tout_cnt + 1'b1;
      end

      if (sample_evt) begin
        case (state)
          IDLE: begin
            if (!data_sync) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift_reg <= {data_sync, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_sync;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_sync && ^{shift_reg, parity_bit}) begin
              case (byte_idx)
                2'd0: begin
                  // Bit 3 of the status byte is always set; use it to resync.
                  if (shift_reg[3]) begin
                    stage_status <= shift_reg;
                    byte_idx     <= 2'd1;
                  end else begin
                    frame_err <= 1'b1;
                  end
                end
                2'd1: begin
                  stage_x  <= shift_reg;
                  byte_idx <= 2'd2;
                end
                2'd2: begin
                  status   <= stage_status;
                  deltaX   <= stage_x;
                  deltaY   <= shift_reg;
                  tx       <= 1'b1;
                  byte_idx <= 2'd0;
                end
                default: byte_idx <= 2'd0;
              endcase
            end else begin
              frame_err <= 1'b1;
              byte_idx  <= 2'd0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (tout_cnt == TOUT_MAX && (state != IDLE || byte_idx != 2'd0)) begin
        // Counter stays saturated, so this fires once per stalled transfer.
        state     <= IDLE;
        byte_idx  <= 2'd0;
        frame_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_packet_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_mouse_packet_rx
// Purpose  : Scoreboard bench for ps2_mouse_packet_rx: directed PS/2 frames,
//            expected packets queued at issue, monitor compares on tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_packet_rx;

  localparam int TOUT = 2000;
  localparam int HALF = 40;

  logic       qzt_clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] status, deltaX, deltaY;
  logic       tx, frame_err;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  int got_err = 0;
  logic prev_tx = 1'b0;
  logic [23:0] exp_q[$];

  ps2_mouse_packet_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TOUT)) dut (
    .qzt_clk   (qzt_clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .status    (status),
    .deltaX    (deltaX),
    .deltaY    (deltaY),
    .tx        (tx),
    .frame_err (frame_err)
  );

  always #5 qzt_clk = ~qzt_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Drive nbits of a frame; data changes while ps2_clk is high.
  task automatic send_bits(input logic [10:0] fr, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      @(negedge qzt_clk);
      ps2_data = fr[i];
      if (glitch) begin
        repeat (10) @(negedge qzt_clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge qzt_clk);
        ps2_clk = 1'b1;
        repeat (HALF - 13) @(negedge qzt_clk);
      end else begin
        repeat (HALF) @(negedge qzt_clk);
      end
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge qzt_clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input bit glitch);
    send_bits(make_frame(b, bad_par), 11, glitch);
    ps2_data = 1'b1;
    repeat (100) @(negedge qzt_clk);
  endtask

  task automatic send_packet(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y, input bit glitch);
    exp_q.push_back({s, x, y});
    send_byte(s, 1'b0, glitch);
    send_byte(x, 1'b0, glitch);
    send_byte(y, 1'b0, glitch);
  endtask

  task automatic checkpoint(input string name);
    repeat (50) @(negedge qzt_clk);
    check({name, "_pending_tx"}, 32'(exp_q.size()), 32'd0);
    check({name, "_frame_err_count"}, 32'(got_err), 32'(exp_err));
  endtask

  // Monitor: pops the scoreboard on every tx, counts frame_err pulses.
  always @(negedge qzt_clk) begin
    if (!reset) begin
      if (tx || frame_err) check("tx_with_frame_err", 32'(tx & frame_err), 32'd0);
      if (tx) begin
        check("tx_back_to_back", 32'(prev_tx), 32'd0);
        check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("packet", 32'({status, deltaX, deltaY}), 32'(exp_q.pop_front()));
      end
      if (frame_err) got_err++;
      prev_tx = tx;
    end else begin
      prev_tx = 1'b0;
    end
  end

  initial begin
    repeat (90000) @(posedge qzt_clk);
    $display("FAIL watchdog: simulation did not complete, got %0d expected 0 remaining cycles", 0);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge qzt_clk);
    check("reset_outputs", 32'({status, deltaX, deltaY, tx, frame_err}), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge qzt_clk);

    // Clean packet
    send_packet(8'h08, 8'h05, 8'hFB, 1'b0);
    checkpoint("t1");

    // Bad parity on byte 1, then a good packet
    send_byte(8'h08, 1'b0, 1'b0);
    exp_err++;
    send_byte(8'h05, 1'b1, 1'b0);
    send_packet(8'h09, 8'h01, 8'h02, 1'b0);
    checkpoint("t2");

    // Resync on a byte with bit3 clear
    exp_err++;
    send_byte(8'h00, 1'b0, 1'b0);
    send_packet(8'h18, 8'hFF, 8'h00, 1'b0);
    checkpoint("t3");

    // Stall after 5 bits of byte 1 -> one timeout error, outputs held
    send_byte(8'h08, 1'b0, 1'b0);
    send_bits(make_frame(8'h07, 1'b0), 5, 1'b0);
    ps2_data = 1'b1;
    exp_err++;
    repeat (TOUT + 300) @(negedge qzt_clk);
    checkpoint("t4_timeout");
    check("t4_outputs_held", 32'({status, deltaX, deltaY}), 32'h0018FF00);
    send_packet(8'h28, 8'h10, 8'hF0, 1'b0);
    checkpoint("t4_after");

    // Short glitches on ps2_clk between bits
    send_packet(8'h0C, 8'h7F, 8'h80, 1'b1);
    checkpoint("t5");

    // Reset during bit 4 of byte 2
    send_byte(8'h08, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    send_bits(make_frame(8'h33, 1'b0), 5, 1'b0);
    ps2_data = 1'b0;
    repeat (20) @(negedge qzt_clk);
    #2 reset = 1'b1;
    #1 check("t6_async_reset_outputs", 32'({status, deltaX, deltaY, tx, frame_err}), 32'd0);
    repeat (10) @(negedge qzt_clk);
    ps2_data = 1'b1;
    reset = 1'b0;
    repeat (50) @(negedge qzt_clk);
    send_packet(8'h09, 8'hAA, 8'h55, 1'b0);
    checkpoint("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
